addsub_rr_arbiter: RTL

Round-robin scheduler that shares one registered WIDTH-bit adder/subtractor among N requesters. Each requester presents operands and an operation, and is granted in turn. The block computes the result and holds it in a one-entry output buffer tagged with the requester index until the consumer accepts it. It sits between the per-channel operand sources and the shared add/sub datapath, and replaces per-channel arithmetic units.

---
 rtl/addsub_rr_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/addsub_rr_arbiter.sv
// Round-robin scheduler sharing one registered add/sub unit among N
// requesters, with a one-entry output buffer tagged by requester index.
module addsub_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int IDW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N*WIDTH-1:0] op_a,
  input  logic [N*WIDTH-1:0] op_b,
  input  logic [N-1:0]     sub,
  output logic [N-1:0]     gnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res,
  output logic [IDW-1:0]   res_id,
  output logic             res_cout,
  output logic             res_ovf
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [IDW-1:0]     r_ptr;
  logic [WIDTH-1:0]   r_res;
  logic [IDW-1:0]     r_resId;
  logic               r_cout;
  logic               r_ovf;

  logic               w_free;
  logic               w_found;
  logic               w_grant;
  logic [IDW-1:0]     w_winner;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic               w_sub;
  logic [WIDTH-1:0]   w_bEff;
  logic [WIDTH:0]     w_sum;
  logic               w_ovf;

  // The buffer can take a new result when empty or when it drains this cycle
  assign w_free  = (r_state == EMPTY) || res_ready;
  assign w_grant = w_free && w_found && !rst;

  // Scan requesters starting at the pointer, wrapping mod N (N is a power of two)
  always_comb begin
    logic [IDW-1:0] idx;
    idx      = '0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N; k++) begin
      idx = r_ptr + IDW'(k);
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  // Select the winner's operands and operation
  always_comb begin
    w_a   = '0;
    w_b   = '0;
    w_sub = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_winner == IDW'(i)) begin
        w_a   = op_a[i*WIDTH +: WIDTH];
        w_b   = op_b[i*WIDTH +: WIDTH];
        w_sub = sub[i];
      end
    end
  end

  // Shared adder: subtraction is A + ~B + 1, overflow from sign agreement
  always_comb begin
    w_bEff = w_sub ? ~w_b : w_b;
    w_sum  = {1'b0, w_a} + {1'b0, w_bEff} + {{WIDTH{1'b0}}, w_sub};
    w_ovf  = (w_a[WIDTH-1] == w_bEff[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  end

  // Buffer state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_nextState;
  end

  // Buffer next state: a grant always fills it, a drain without grant empties it
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      EMPTY: if (w_grant) w_nextState = FULL;
      FULL:  if (res_ready && !w_grant) w_nextState = EMPTY;
      default: w_nextState = EMPTY;
    endcase
  end

  // Buffer outputs and one-hot grant strobe
  always_comb begin
    res_valid = (r_state == FULL);
    gnt       = '0;
    if (w_grant) gnt[w_winner] = 1'b1;
  end

  // Result payload and round-robin pointer, updated only on a grant
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_res   <= '0;
      r_resId <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_grant) begin
      r_ptr   <= w_winner + IDW'(1);
      r_res   <= w_sum[WIDTH-1:0];
      r_resId <= w_winner;
      r_cout  <= w_sum[WIDTH];
      r_ovf   <= w_ovf;
    end
  end

  assign res      = r_res;
  assign res_id   = r_resId;
  assign res_cout = r_cout;
  assign res_ovf  = r_ovf;

endmodule
